// File: rtl/sdram_arbiter.sv
// Two-port SDRAM command arbiter: CPU/GPU share one controller port.
// GPU has priority, but a CPU that waits out CPU_MAX_WAIT GPU grants wins.
module sdram_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_ack,
  output logic              gpu_rvalid,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic              ctrl_valid,
  output logic              ctrl_we,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wdata,
  input  logic              ctrl_ready,
  input  logic              ctrl_rdata_valid,
  input  logic [DATA_W-1:0] ctrl_rdata
);

  localparam int WW = $clog2(CPU_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RD_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_own_vld;
  logic            r_own_gpu;
  logic [WW-1:0]   r_cpu_wait;
  logic            r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic w_idle;
  logic w_cpu_prio;
  logic w_grant_cpu;
  logic w_grant_gpu;
  logic w_accept;
  logic w_rdone;

  assign w_idle      = (r_state == S_IDLE);
  assign w_cpu_prio  = (r_cpu_wait >= WW'(CPU_MAX_WAIT));
  assign w_grant_cpu = w_idle & cpu_req & (~gpu_req | w_cpu_prio);
  assign w_grant_gpu = w_idle & gpu_req & ~w_grant_cpu;
  assign w_accept    = (r_state == S_CMD) & ctrl_ready;
  assign w_rdone     = (r_state == S_RD_WAIT) & ctrl_rdata_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_grant_cpu | w_grant_gpu) w_next = S_CMD;
      S_CMD:     if (ctrl_ready) w_next = r_we ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: if (ctrl_rdata_valid) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_valid = (r_state == S_CMD);
    cpu_ack    = w_accept & r_own_vld & ~r_own_gpu;
    gpu_ack    = w_accept & r_own_vld &  r_own_gpu;
    cpu_rvalid = w_rdone  & r_own_vld & ~r_own_gpu;
    gpu_rvalid = w_rdone  & r_own_vld &  r_own_gpu;
  end

  assign ctrl_we    = r_we;
  assign ctrl_addr  = r_addr;
  assign ctrl_wdata = r_wdata;
  assign cpu_rdata  = ctrl_rdata;
  assign gpu_rdata  = ctrl_rdata;

  // Command fields are captured at grant so they stay frozen through CMD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own_vld <= 1'b0;
      r_own_gpu <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_grant_cpu) begin
      r_own_vld <= 1'b1;
      r_own_gpu <= 1'b0;
      r_we      <= cpu_we;
      r_addr    <= cpu_addr;
      r_wdata   <= cpu_wdata;
    end else if (w_grant_gpu) begin
      r_own_vld <= 1'b1;
      r_own_gpu <= 1'b1;
      r_we      <= gpu_we;
      r_addr    <= gpu_addr;
      r_wdata   <= gpu_wdata;
    end else if ((w_accept & r_we) | w_rdone) begin
      r_own_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_wait <= '0;
    end else if (w_grant_cpu) begin
      r_cpu_wait <= '0;
    end else if (w_grant_gpu & cpu_req & ~w_cpu_prio) begin
      r_cpu_wait <= r_cpu_wait + WW'(1);
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: handshakes, stalls, reads, reset abort,
// spurious read returns and CPU anti-starvation ordering.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, gpu_req, gpu_we;
  logic [23:0] cpu_addr, gpu_addr;
  logic [15:0] cpu_wdata, gpu_wdata;
  logic        cpu_ack, cpu_rvalid, gpu_ack, gpu_rvalid;
  logic [15:0] cpu_rdata, gpu_rdata;
  logic        ctrl_valid, ctrl_we;
  logic [23:0] ctrl_addr;
  logic [15:0] ctrl_wdata;
  logic        ctrl_ready, ctrl_rdata_valid;
  logic [15:0] ctrl_rdata;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .gpu_req(gpu_req), .gpu_we(gpu_we),
    .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_ack(gpu_ack), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .ctrl_valid(ctrl_valid), .ctrl_we(ctrl_we),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_ready(ctrl_ready), .ctrl_rdata_valid(ctrl_rdata_valid),
    .ctrl_rdata(ctrl_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge, then settle combinational outputs
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  grants;
    int  cyc_cnt;
    logic got_cpu;

    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    gpu_req = 0; gpu_we = 0; gpu_addr = 0; gpu_wdata = 0;
    ctrl_ready = 1; ctrl_rdata_valid = 0; ctrl_rdata = 0;

    // reset values
    cyc(); cyc();
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_we", ctrl_we, 0);
    chk("rst_addr", ctrl_addr, 0);
    chk("rst_wdata", ctrl_wdata, 0);
    chk("rst_acks", {cpu_ack, gpu_ack, cpu_rvalid, gpu_rvalid}, 0);
    rst_n = 1'b1;

    // CPU write, ready tied high
    cyc();
    cpu_req = 1; cpu_we = 1; cpu_addr = 24'h000010; cpu_wdata = 16'hBEEF;
    #1 chk("wr_c0_valid", ctrl_valid, 0);
    cyc();
    chk("wr_c1_valid", ctrl_valid, 1);
    chk("wr_c1_addr", ctrl_addr, 32'h10);
    chk("wr_c1_wdata", ctrl_wdata, 32'hBEEF);
    chk("wr_c1_we", ctrl_we, 1);
    chk("wr_c1_acks", {cpu_ack, gpu_ack}, 2'b10);
    cpu_req = 0;
    cyc();
    chk("wr_c2_idle", {ctrl_valid, cpu_ack}, 0);

    // GPU read, data back 3 cycles after accept
    gpu_req = 1; gpu_we = 0; gpu_addr = 24'h000100;
    cyc();
    chk("rd_c1_valid", ctrl_valid, 1);
    chk("rd_c1_addr", ctrl_addr, 32'h100);
    chk("rd_c1_acks", {cpu_ack, gpu_ack}, 2'b01);
    gpu_req = 0;
    cyc();
    chk("rd_wait_valid", ctrl_valid, 0);
    cyc();
    @(negedge clk);
    ctrl_rdata_valid = 1; ctrl_rdata = 16'h1234;
    #1;
    chk("rd_rvalid", {cpu_rvalid, gpu_rvalid}, 2'b01);
    chk("rd_rdata", gpu_rdata, 32'h1234);
    @(negedge clk);
    ctrl_rdata_valid = 0;
    #1;
    chk("rd_pulse_end", {cpu_rvalid, gpu_rvalid, ctrl_valid}, 0);

    // GPU write stalled by ctrl_ready=0 for 5 cycles
    ctrl_ready = 0;
    gpu_req = 1; gpu_we = 1; gpu_addr = 24'hABCDEF; gpu_wdata = 16'h5A5A;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk($sformatf("stall_%0d", i),
          {ctrl_valid, gpu_ack, ctrl_wdata, ctrl_addr}, {2'b10, 16'h5A5A, 24'hABCDEF});
    end
    @(negedge clk);
    ctrl_ready = 1;
    #1 chk("stall_ack6", {ctrl_valid, gpu_ack}, 2'b11);
    gpu_req = 0;
    cyc();
    chk("stall_done", ctrl_valid, 0);

    // spurious read return in IDLE
    @(negedge clk);
    ctrl_rdata_valid = 1;
    #1 chk("spur_rvalid", {cpu_rvalid, gpu_rvalid, ctrl_valid}, 0);
    cyc();
    ctrl_rdata_valid = 0;
    chk("spur_state", ctrl_valid, 0);

    // reset in RD_WAIT: GPU read beats waiting CPU (cpu_wait -> 1)
    gpu_req = 1; gpu_we = 0; gpu_addr = 24'h000200;
    cpu_req = 1; cpu_we = 0; cpu_addr = 24'h000300;
    cyc();
    chk("ab_gpu_ack", {cpu_ack, gpu_ack}, 2'b01);
    gpu_req = 0; cpu_req = 0;
    cyc();
    chk("ab_wait1", dut.r_cpu_wait, 1);
    rst_n = 0;
    #1;
    chk("ab_rst_out", {ctrl_valid, ctrl_we, ctrl_addr, ctrl_wdata}, 0);
    chk("ab_rst_wait", dut.r_cpu_wait, 0);
    cyc();
    rst_n = 1;
    @(negedge clk);
    ctrl_rdata_valid = 1;
    #1 chk("ab_no_rvalid", {cpu_rvalid, gpu_rvalid, ctrl_valid}, 0);
    cyc();
    ctrl_rdata_valid = 0;

    // both held: expect G x8, C, G x8, C
    cpu_req = 1; cpu_we = 1; cpu_addr = 24'h1; cpu_wdata = 16'h1;
    gpu_req = 1; gpu_we = 1; gpu_addr = 24'h2; gpu_wdata = 16'h2;
    grants = 0;
    cyc_cnt = 0;
    while (grants < 18 && cyc_cnt < 100) begin
      cyc();
      cyc_cnt++;
      if (cpu_ack | gpu_ack) begin
        got_cpu = cpu_ack;
        chk($sformatf("arb_%0d", grants), {cpu_ack, gpu_ack},
            ((grants % 9) == 8) ? 2'b10 : 2'b01);
        grants++;
      end
    end
    chk("arb_count", grants, 18);
    chk("arb_last_cpu", got_cpu, 1);
    cpu_req = 0; gpu_req = 0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
